// File: rtl/jk_chk_pkg.sv
// Shared types and the JK next-state rule used by jk_ff_checker.
// Mode encoding follows the {j,k} pin pair so a sampled pair casts straight to a mode.
package jk_chk_pkg;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        CHECK  = 2'd1,
        HALT   = 2'd2
    } chk_state_e;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_mode_e;

    function automatic jk_mode_e jk_mode(input logic j, input logic k);
        return jk_mode_e'({j, k});
    endfunction

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nq;
        case (jk_mode(j, k))
            JK_HOLD: nq = q;
            JK_SET:  nq = 1'b1;
            JK_RST:  nq = 1'b0;
            default: nq = ~q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/jk_ff_checker.sv
// Observer for a JK flip-flop with async preset/clear: predicts Q each edge and flags mismatches.
// Optional coverage counters are built only when the macro JK_COV_EN is defined.
module jk_ff_checker #(
    parameter int ERR_CNT_W   = 8,
    parameter int COV_W       = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 j,
    input  logic                 k,
    input  logic                 q,
    input  logic                 qn,
    input  logic                 dut_preset_n,
    input  logic                 dut_clr_n,
    output logic                 mismatch,
    output logic                 qn_err,
    output logic                 illegal_async,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           chk_state
`ifdef JK_COV_EN
    ,
    output logic [COV_W-1:0]     cov_hold,
    output logic [COV_W-1:0]     cov_set,
    output logic [COV_W-1:0]     cov_rst,
    output logic [COV_W-1:0]     cov_tgl,
    output logic                 cov_all_hit
`endif
);

    import jk_chk_pkg::*;

    if (ERR_CNT_W < 1 || COV_W < 1) begin : g_bad_width
        $error("jk_ff_checker: counter widths must be at least 1");
    end

    chk_state_e state;
    logic       exp_q;
    logic       exp_vld;

    logic async_act;
    logic async_both;
    logic in_check;
    logic q_bad;
    logic qn_bad;
    logic err_event;
    logic base_q;

    assign async_act  = !dut_preset_n || !dut_clr_n;
    assign async_both = !dut_preset_n && !dut_clr_n;
    assign in_check   = (state == CHECK) && en;
    assign q_bad      = in_check && exp_vld && (q != exp_q);
    assign qn_bad     = in_check && (qn == q);
    assign err_event  = q_bad || qn_bad;

    // The prediction runs from its own expectation while valid, so a stuck DUT keeps
    // being caught instead of the checker re-syncing onto the faulty value.
    assign base_q     = exp_vld ? exp_q : q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= UNSYNC;
            exp_q         <= 1'b0;
            exp_vld       <= 1'b0;
            mismatch      <= 1'b0;
            qn_err        <= 1'b0;
            illegal_async <= 1'b0;
        end else if (state == HALT) begin
            mismatch      <= 1'b0;
            qn_err        <= 1'b0;
            illegal_async <= 1'b0;
        end else begin
            mismatch      <= q_bad;
            qn_err        <= qn_bad;
            illegal_async <= async_both;
            if (!en) begin
                state   <= UNSYNC;
                exp_vld <= 1'b0;
            end else if (async_act) begin
                exp_vld <= 1'b0;
            end else begin
                exp_q   <= jk_next(base_q, j, k);
                exp_vld <= 1'b1;
                if (state == UNSYNC) begin
                    state <= CHECK;
                end
            end
            if ((STOP_ON_ERR != 0) && err_event) begin
                state <= HALT;
            end
        end
    end

    assign chk_state = state;

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_event),
        .clr   (1'b0),
        .count (err_cnt)
    );

`ifdef JK_COV_EN
    jk_mode_e mode;
    assign mode = jk_mode(j, k);

    sat_counter #(.W(COV_W)) u_cov_hold (
        .clk(clk), .rst(rst), .inc(in_check && (mode == JK_HOLD)), .clr(1'b0), .count(cov_hold)
    );
    sat_counter #(.W(COV_W)) u_cov_set (
        .clk(clk), .rst(rst), .inc(in_check && (mode == JK_SET)), .clr(1'b0), .count(cov_set)
    );
    sat_counter #(.W(COV_W)) u_cov_rst (
        .clk(clk), .rst(rst), .inc(in_check && (mode == JK_RST)), .clr(1'b0), .count(cov_rst)
    );
    sat_counter #(.W(COV_W)) u_cov_tgl (
        .clk(clk), .rst(rst), .inc(in_check && (mode == JK_TGL)), .clr(1'b0), .count(cov_tgl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cov_all_hit <= 1'b0;
        end else if (state != HALT) begin
            cov_all_hit <= (cov_hold != '0) && (cov_set != '0) &&
                           (cov_rst != '0) && (cov_tgl != '0);
        end
    end
`endif

endmodule
